// File: rtl/ring_sequencer.sv
// ring_sequencer: one-hot N-channel rotate/bounce sequencer with per-step dwell; all outputs registered, no backpressure.
// Optional RING_SEQ_LOAD_EN adds load/load_idx for a direct index jump.
module ring_sequencer #(
  parameter int N       = 4,
  parameter int DWELL_W = 4,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
`ifdef RING_SEQ_LOAD_EN
  input  logic               load,
  input  logic [IDX_W-1:0]   load_idx,
`endif
  output logic [N-1:0]       signal,
  output logic [IDX_W-1:0]   index,
  output logic               cur_dir,
  output logic               step_pulse,
  output logic               wrap
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [N-1:0]     SIG_RST = {1'b1, {(N-1){1'b0}}};

  logic [IDX_W-1:0]   r_index;
  logic [N-1:0]       r_signal;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_cur_dir;
  logic               r_step;
  logic               r_wrap;

  logic [IDX_W-1:0]   w_nxt_idx;
  logic               w_nxt_dir;
  logic               w_nxt_wrap;
  logic               w_step;

  assign w_step = en && (r_cnt >= dwell);

  // Rotate steps follow the live dir input; bounce follows the stored direction.
  always_comb begin
    w_nxt_idx  = r_index;
    w_nxt_dir  = r_cur_dir;
    w_nxt_wrap = 1'b0;
    if (!mode) begin
      w_nxt_dir = dir;
      if (!dir) begin
        if (r_index == LAST) begin
          w_nxt_idx  = '0;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_idx = r_index + ONE;
        end
      end else begin
        if (r_index == '0) begin
          w_nxt_idx  = LAST;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_idx = r_index - ONE;
        end
      end
    end else begin
      if (!r_cur_dir) begin
        if (r_index == LAST) begin
          // Entered bounce at the top end while pointing outward: reverse now.
          w_nxt_idx  = LAST - ONE;
          w_nxt_dir  = 1'b1;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_idx = r_index + ONE;
          if (r_index == LAST - ONE) begin
            w_nxt_dir  = 1'b1;
            w_nxt_wrap = 1'b1;
          end
        end
      end else begin
        if (r_index == '0) begin
          w_nxt_idx  = ONE;
          w_nxt_dir  = 1'b0;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_idx = r_index - ONE;
          if (r_index == ONE) begin
            w_nxt_dir  = 1'b0;
            w_nxt_wrap = 1'b1;
          end
        end
      end
    end
  end

`ifdef RING_SEQ_LOAD_EN
  logic [IDX_W-1:0] w_load_idx;
  assign w_load_idx = (int'(load_idx) >= N) ? '0 : load_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index   <= '0;
      r_signal  <= SIG_RST;
      r_cnt     <= '0;
      r_cur_dir <= 1'b0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      // In rotate mode the reported direction tracks dir even while frozen.
      if (!mode) r_cur_dir <= dir;
`ifdef RING_SEQ_LOAD_EN
      if (load) begin
        r_index  <= w_load_idx;
        r_signal <= SIG_RST >> w_load_idx;
        r_cnt    <= '0;
        r_step   <= 1'b1;
      end else
`endif
      if (w_step) begin
        r_index  <= w_nxt_idx;
        r_signal <= SIG_RST >> w_nxt_idx;
        r_cnt    <= '0;
        r_step   <= 1'b1;
        r_wrap   <= w_nxt_wrap;
        if (mode) r_cur_dir <= w_nxt_dir;
      end else if (en) begin
        r_cnt <= r_cnt + DWELL_W'(1);
      end
    end
  end

  assign signal     = r_signal;
  assign index      = r_index;
  assign cur_dir    = r_cur_dir;
  assign step_pulse = r_step;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_ring_sequencer.sv
// Scoreboard bench for ring_sequencer: a position/counter model predicts every cycle's outputs.
module tb_ring_sequencer;
  localparam int N       = 4;
  localparam int DWELL_W = 4;
  localparam int IDX_W   = $clog2(N);

  logic               clk = 1'b0;
  logic               reset, en, dir, mode;
  logic [DWELL_W-1:0] dwell;
`ifdef RING_SEQ_LOAD_EN
  logic               load;
  logic [IDX_W-1:0]   load_idx;
`endif
  logic [N-1:0]       signal;
  logic [IDX_W-1:0]   index;
  logic               cur_dir, step_pulse, wrap;

  ring_sequencer #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .dwell(dwell),
`ifdef RING_SEQ_LOAD_EN
    .load(load), .load_idx(load_idx),
`endif
    .signal(signal), .index(index), .cur_dir(cur_dir),
    .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     sig;
    logic [IDX_W-1:0] idx;
    logic             cd;
    logic             sp;
    logic             wr;
  } exp_t;

  exp_t q[$];
  int   m_pos = 0, m_cnt = 0;
  bit   m_dir = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  bit   done = 1'b0;

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic drive(input bit r, input bit e, input bit d, input bit m, input int dw,
                       input bit ld = 1'b0, input int li = 0);
    exp_t         x;
    bit           stp, wr;
    int           np, s;
    logic [N-1:0] one;
    reset = r; en = e; dir = d; mode = m; dwell = DWELL_W'(dw);
`ifdef RING_SEQ_LOAD_EN
    load = ld; load_idx = IDX_W'(li);
`endif
    stp = 1'b0; wr = 1'b0;
    if (r) begin
      m_pos = 0; m_cnt = 0; m_dir = 1'b0;
    end else begin
      if (ld) begin
        m_pos = (li >= N) ? 0 : li;
        m_cnt = 0;
        stp   = 1'b1;
      end else if (e) begin
        if (m_cnt >= dw) begin
          stp = 1'b1; m_cnt = 0;
          if (!m) begin
            np = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            wr = d ? (m_pos == 0) : (m_pos == N - 1);
          end else begin
            s  = m_dir ? -1 : 1;
            np = m_pos + s;
            if (np < 0 || np > N - 1) begin
              np = m_pos - s; m_dir = !m_dir; wr = 1'b1;
            end else if (np == N - 1) begin
              m_dir = 1'b1; wr = 1'b1;
            end else if (np == 0) begin
              m_dir = 1'b0; wr = 1'b1;
            end
          end
          m_pos = np;
        end else begin
          m_cnt++;
        end
      end
      if (!m) m_dir = d;
    end
    one   = 1;
    x.sig = one << (N - 1 - m_pos);
    x.idx = IDX_W'(m_pos);
    x.cd  = m_dir;
    x.sp  = stp;
    x.wr  = wr;
    q.push_back(x);
    @(negedge clk);
  endtask

  function automatic void chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endfunction

  initial begin : stimulus
    bit r_mode = 1'b0, r_dir = 1'b0;
    int r_dw = 0;
    drive(1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 0);             // rotate up, dwell 0
    drive(1, 0, 0, 0, 0);
    repeat (9) drive(0, 1, 0, 0, 2);             // dwell 2
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 5);             // cnt reaches 3, then dwell drops
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (5) drive(0, 1, 1, 0, 0);             // rotate down
    drive(1, 0, 0, 0, 0);
    repeat (10) drive(0, 1, 0, 1, 0);            // bounce
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0);             // freeze at index 2
    repeat (2) drive(0, 1, 0, 0, 3);
    drive(1, 1, 0, 0, 3);                         // reset mid-dwell
    drive(0, 1, 0, 0, 3);
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0);                         // enter bounce at top pointing up
    drive(0, 1, 0, 1, 0);
`ifdef RING_SEQ_LOAD_EN
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, 0, 1, 0);
`endif
    for (int i = 0; i < 600; i++) begin
      bit ld;
      if ($urandom_range(0, 19) == 0) r_mode = !r_mode;
      if ($urandom_range(0, 7) == 0) r_dir = !r_dir;
      if ($urandom_range(0, 9) == 0)
        r_dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      ld = 1'b0;
`ifdef RING_SEQ_LOAD_EN
      ld = ($urandom_range(0, 19) == 0);
`endif
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 85, r_dir, r_mode, r_dw,
            ld, $urandom_range(0, (1 << IDX_W) - 1));
    end
    done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    int   cyc_n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (q.size() == 0) begin
        if (done) break;
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty cycle=%0d got=no_expectation expected=queued_entry", cyc_n);
      end else begin
        e = q.pop_front();
        chk("signal",     cyc_n, 32'(signal),     32'(e.sig));
        chk("index",      cyc_n, 32'(index),      32'(e.idx));
        chk("cur_dir",    cyc_n, 32'(cur_dir),    32'(e.cd));
        chk("step_pulse", cyc_n, 32'(step_pulse), 32'(e.sp));
        chk("wrap",       cyc_n, 32'(wrap),       32'(e.wr));
      end
      if (cyc_n > 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout cycle=%0d got=running expected=done", cyc_n);
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
